// File: rtl/dbg_bus_master.sv
// Byte-stream bus initiator: parses 'W'/'R' commands from UART bytes, wins the bridge from the CPU, returns read data.
// Optional macro DBG_WRITE_ACK_EN: writes answer with a single 'K' byte.
module dbg_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  CMD_WRITE      = 8'h57,
    parameter logic [7:0]  CMD_READ       = 8'h52
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [31:0] dev_addr,
    output logic [31:0] dev_wdata,
    output logic        dev_we,
    input  logic [31:0] dev_rdata,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, REQ, ACCESS, RESP} state_t;

    localparam int unsigned   TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t        r_state;
    state_t        w_nextState;
    logic          r_isWrite;
    logic [1:0]    r_byteCnt;
    logic [1:0]    r_txIdx;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic [TW-1:0] r_timer;
    logic          r_overrun;

    logic w_isCmd;
    logic w_collecting;
    logic w_timeout;
    logic w_txFire;
    logic w_lastTx;
    logic w_busOwned;

    assign w_isCmd      = (rx_data == CMD_WRITE) || (rx_data == CMD_READ);
    assign w_collecting = (r_state == ADDR) || (r_state == DATA);
    // A byte arriving in the expiring cycle takes priority over the timeout.
    assign w_timeout    = (TIMEOUT_CYCLES != 0) && w_collecting && !rx_valid && (r_timer == TLAST);
    assign w_txFire     = (r_state == RESP) && tx_ready;
    assign w_lastTx     = r_isWrite || (r_txIdx == 2'd3);
    assign w_busOwned   = (r_state == REQ) || (r_state == ACCESS) || (r_state == RESP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (rx_valid && w_isCmd) w_nextState = ADDR;
            end
            ADDR: begin
                if (rx_valid && r_byteCnt == 2'd3) w_nextState = r_isWrite ? DATA : REQ;
                else if (w_timeout)                w_nextState = IDLE;
            end
            DATA: begin
                if (rx_valid && r_byteCnt == 2'd3) w_nextState = REQ;
                else if (w_timeout)                w_nextState = IDLE;
            end
            REQ: begin
                if (bus_gnt) w_nextState = ACCESS;
            end
            ACCESS: begin
`ifdef DBG_WRITE_ACK_EN
                w_nextState = RESP;
`else
                w_nextState = r_isWrite ? IDLE : RESP;
`endif
            end
            RESP: begin
                if (w_txFire && w_lastTx) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_isWrite <= 1'b0;
            r_byteCnt <= 2'd0;
            r_txIdx   <= 2'd0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_rdata   <= 32'd0;
            r_timer   <= '0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (rx_valid && w_isCmd) begin
                        r_isWrite <= (rx_data == CMD_WRITE);
                        r_byteCnt <= 2'd0;
                        r_timer   <= '0;
                    end
                end
                ADDR, DATA: begin
                    if (rx_valid) begin
                        if (r_state == ADDR) r_addr  <= {r_addr[23:0], rx_data};
                        else                 r_wdata <= {r_wdata[23:0], rx_data};
                        r_byteCnt <= r_byteCnt + 2'd1;
                        r_timer   <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ACCESS: begin
                    if (!r_isWrite) r_rdata <= dev_rdata;
                    r_txIdx <= 2'd0;
                end
                RESP: begin
                    if (w_txFire) r_txIdx <= r_txIdx + 2'd1;
                end
                default: ;
            endcase
            if (rx_valid && w_busOwned) r_overrun <= 1'b1;
        end
    end

    always_comb begin
        bus_req  = 1'b0;
        dev_we   = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (r_state)
            REQ: bus_req = 1'b1;
            ACCESS: begin
                bus_req = 1'b1;
                dev_we  = r_isWrite;
            end
            RESP: begin
                tx_valid = 1'b1;
                case (r_txIdx)
                    2'd0:    tx_data = r_rdata[31:24];
                    2'd1:    tx_data = r_rdata[23:16];
                    2'd2:    tx_data = r_rdata[15:8];
                    default: tx_data = r_rdata[7:0];
                endcase
`ifdef DBG_WRITE_ACK_EN
                if (r_isWrite) tx_data = 8'h4B;
`endif
            end
            default: ;
        endcase
    end

    assign busy      = (r_state != IDLE);
    assign overrun   = r_overrun;
    assign dev_addr  = {r_addr[31:2], 2'b00};
    assign dev_wdata = r_wdata;

endmodule

// File: tb/tb_dbg_bus_master.sv
// Bench for dbg_bus_master: queue-based command/response model checked every cycle, plus directed literal checks.
// Honours DBG_WRITE_ACK_EN when the design is built with it.
module tb_dbg_bus_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        bus_req;
    logic        bus_gnt = 1'b1;
    logic [31:0] dev_addr;
    logic [31:0] dev_wdata;
    logic        dev_we;
    logic [31:0] dev_rdata;
    logic        busy;
    logic        overrun;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lastRx = 0;
    bit randomDrv = 1'b0;

    dbg_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .dev_addr(dev_addr),
        .dev_wdata(dev_wdata), .dev_we(dev_we), .dev_rdata(dev_rdata),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Device read mux stand-in: one fixed register plus an address-derived pattern.
    function automatic logic [31:0] memF(input logic [31:0] a);
        if (a == 32'h00007F2C) return 32'hDEADBEEF;
        return (a * 32'h01010101) ^ 32'h13572468;
    endfunction

    assign dev_rdata = memF(dev_addr);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: bytes collected so far, pending bus phases, and a queue of bytes still owed to tx.
    logic [7:0]  mq[$];
    logic [7:0]  respQ[$];
    int          silent = 0;
    bit          reqPh = 1'b0;
    bit          accPh = 1'b0;
    bit          mOv = 1'b0;
    bit          cWr = 1'b0;
    logic [31:0] cAddr = 32'd0;
    logic [31:0] cData = 32'd0;
    logic [31:0] mRd;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            respQ.delete();
            silent = 0;
            reqPh = 1'b0;
            accPh = 1'b0;
            mOv = 1'b0;
        end else if (respQ.size() > 0) begin
            if (rx_valid) mOv = 1'b1;
            if (tx_ready) void'(respQ.pop_front());
        end else if (accPh) begin
            if (rx_valid) mOv = 1'b1;
            accPh = 1'b0;
            if (!cWr) begin
                mRd = memF(cAddr);
                for (int i = 3; i >= 0; i--) respQ.push_back(mRd[8*i +: 8]);
            end
`ifdef DBG_WRITE_ACK_EN
            else respQ.push_back(8'h4B);
`endif
        end else if (reqPh) begin
            if (rx_valid) mOv = 1'b1;
            if (bus_gnt) begin
                reqPh = 1'b0;
                accPh = 1'b1;
            end
        end else if (mq.size() == 0) begin
            if (rx_valid && (rx_data == 8'h57 || rx_data == 8'h52)) begin
                mq.push_back(rx_data);
                silent = 0;
            end
        end else if (rx_valid) begin
            mq.push_back(rx_data);
            silent = 0;
            if (mq.size() == ((mq[0] == 8'h57) ? 9 : 5)) begin
                cWr = (mq[0] == 8'h57);
                cAddr = {mq[1], mq[2], mq[3], mq[4]} & 32'hFFFF_FFFC;
                if (cWr) cData = {mq[5], mq[6], mq[7], mq[8]};
                mq.delete();
                reqPh = 1'b1;
            end
        end else begin
            silent++;
            if (silent == TO) mq.delete();
        end
    end

    int          weCyc[$];
    logic [31:0] weAddr[$];
    logic [31:0] weData[$];
    logic [7:0]  txB[$];
    int          txC[$];
    int          reqCnt = 0;
    int          fallCyc = -1;
    bit          prevBusy = 1'b0;

    // Per-cycle comparison against the model, plus event logs for the directed checks.
    always @(negedge clk) begin
        checkOutput("busy", 32'(busy), 32'(mq.size() > 0 || reqPh || accPh || respQ.size() > 0));
        checkOutput("bus_req", 32'(bus_req), 32'(reqPh || accPh));
        checkOutput("dev_we", 32'(dev_we), 32'(accPh && cWr));
        checkOutput("tx_valid", 32'(tx_valid), 32'(respQ.size() > 0));
        checkOutput("overrun", 32'(overrun), 32'(mOv));
        if (respQ.size() > 0) checkOutput("tx_data", 32'(tx_data), 32'(respQ[0]));
        if (accPh) checkOutput("dev_addr", dev_addr, cAddr);
        if (accPh && cWr) checkOutput("dev_wdata", dev_wdata, cData);
        if (!reset) begin
            if (dev_we) begin
                weCyc.push_back(cyc);
                weAddr.push_back(dev_addr);
                weData.push_back(dev_wdata);
            end
            if (tx_valid && tx_ready) begin
                txB.push_back(tx_data);
                txC.push_back(cyc);
            end
            if (bus_req) reqCnt++;
            if (prevBusy && !busy) fallCyc = cyc;
            prevBusy = busy;
        end
    end

    logic [7:0] cmdQ[$];

    task automatic stepHandshake();
        if (randomDrv) begin
            tx_ready = 1'($urandom_range(0, 1));
            if (!bus_req || !bus_gnt) bus_gnt = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(posedge clk);
        #2;
        rx_valid = 1'b1;
        rx_data = b;
        lastRx = cyc;
        stepHandshake();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            rx_valid = 1'b0;
            stepHandshake();
        end
    endtask

    task automatic applyStimulus(input int maxGap);
        foreach (cmdQ[i]) begin
            sendByte(cmdQ[i]);
            if (maxGap > 0) idle($urandom_range(0, maxGap));
        end
        idle(1);
    endtask

    task automatic waitIdle(input int maxc);
        int k = 0;
        while (busy && k < maxc) begin
            idle(1);
            k++;
        end
        if (busy) checkOutput("wait_idle_bound", 32'(busy), 32'd0);
    endtask

    int ws, ts, rs, g, trunc;
    logic [31:0] ra, rd;
    bit op;

    initial begin
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("rst_bus_req", 32'(bus_req), 32'd0);
        checkOutput("rst_dev_addr", dev_addr, 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);

        // Write with the bus already granted.
        ws = weCyc.size(); ts = txB.size(); rs = reqCnt;
        cmdQ = '{8'h57, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0A};
        applyStimulus(0);
        idle(8);
        checkOutput("wr_we_count", 32'(weCyc.size() - ws), 32'd1);
        if (weCyc.size() > ws) begin
            checkOutput("wr_we_cycle", 32'(weCyc[ws]), 32'(lastRx + 2));
            checkOutput("wr_addr", weAddr[ws], 32'h00007F00);
            checkOutput("wr_data", weData[ws], 32'h0000000A);
        end
        checkOutput("wr_req_cycles", 32'(reqCnt - rs), 32'd2);
`ifdef DBG_WRITE_ACK_EN
        checkOutput("wr_ack_count", 32'(txB.size() - ts), 32'd1);
        if (txB.size() > ts) checkOutput("wr_ack_byte", 32'(txB[ts]), 32'h4B);
`else
        checkOutput("wr_tx_count", 32'(txB.size() - ts), 32'd0);
`endif

        // Read of the fixed register, unaligned address.
        ws = weCyc.size(); ts = txB.size();
        cmdQ = '{8'h52, 8'h00, 8'h00, 8'h7F, 8'h2F};
        applyStimulus(0);
        idle(10);
        checkOutput("rd_tx_count", 32'(txB.size() - ts), 32'd4);
        checkOutput("rd_no_we", 32'(weCyc.size() - ws), 32'd0);
        checkOutput("rd_addr_hold", dev_addr, 32'h00007F2C);
        if (txB.size() >= ts + 4) begin
            checkOutput("rd_byte0", 32'(txB[ts]), 32'hDE);
            checkOutput("rd_byte1", 32'(txB[ts+1]), 32'hAD);
            checkOutput("rd_byte2", 32'(txB[ts+2]), 32'hBE);
            checkOutput("rd_byte3", 32'(txB[ts+3]), 32'hEF);
            checkOutput("rd_first_cycle", 32'(txC[ts]), 32'(lastRx + 3));
            checkOutput("rd_last_cycle", 32'(txC[ts+3]), 32'(lastRx + 6));
        end

        // Arbitration: grant withheld for 50 cycles.
        bus_gnt = 1'b0;
        ws = weCyc.size();
        cmdQ = '{8'h57, 8'h12, 8'h34, 8'h56, 8'h78, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        applyStimulus(0);
        idle(50);
        checkOutput("arb_no_we", 32'(weCyc.size() - ws), 32'd0);
        checkOutput("arb_req_held", 32'(bus_req), 32'd1);
        @(posedge clk);
        #2;
        bus_gnt = 1'b1;
        g = cyc;
        idle(6);
        checkOutput("arb_we_count", 32'(weCyc.size() - ws), 32'd1);
        if (weCyc.size() > ws) begin
            checkOutput("arb_we_cycle", 32'(weCyc[ws]), 32'(g + 1));
            checkOutput("arb_addr", weAddr[ws], 32'h12345678);
            checkOutput("arb_data", weData[ws], 32'hCAFEF00D);
        end

        // Inter-byte timeout, then a clean read.
        cmdQ = '{8'h57, 8'h00, 8'h00};
        applyStimulus(0);
        idle(30);
        checkOutput("to_fall_cycle", 32'(fallCyc), 32'(lastRx + TO + 1));
        ts = txB.size();
        cmdQ = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h04};
        applyStimulus(0);
        idle(10);
        checkOutput("to_rd_count", 32'(txB.size() - ts), 32'd4);
        if (txB.size() >= ts + 4)
            checkOutput("to_rd_word", {txB[ts], txB[ts+1], txB[ts+2], txB[ts+3]}, 32'h1753206C);

        // Garbage in IDLE, overrun during a stalled response, then async reset.
        sendByte(8'h41);
        idle(3);
        checkOutput("garbage_busy", 32'(busy), 32'd0);
        checkOutput("garbage_overrun", 32'(overrun), 32'd0);
        tx_ready = 1'b0;
        cmdQ = '{8'h52, 8'h00, 8'h00, 8'h7F, 8'h2C};
        applyStimulus(0);
        idle(6);
        sendByte(8'h52);
        idle(2);
        checkOutput("ovr_flag", 32'(overrun), 32'd1);
        checkOutput("ovr_tx_valid", 32'(tx_valid), 32'd1);
        checkOutput("ovr_tx_data", 32'(tx_data), 32'hDE);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("arst_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("arst_bus_req", 32'(bus_req), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_overrun", 32'(overrun), 32'd0);
        idle(2);
        reset = 1'b0;
        tx_ready = 1'b1;
        idle(2);

        // Randomized commands, gaps, grants, tx backpressure and abandoned commands.
        randomDrv = 1'b1;
        for (int n = 0; n < 80; n++) begin
            waitIdle(400);
            op = 1'($urandom_range(0, 1));
            ra = $urandom;
            rd = $urandom;
            cmdQ.delete();
            cmdQ.push_back(op ? 8'h57 : 8'h52);
            for (int i = 3; i >= 0; i--) cmdQ.push_back(ra[8*i +: 8]);
            if (op) for (int i = 3; i >= 0; i--) cmdQ.push_back(rd[8*i +: 8]);
            case ($urandom_range(0, 9))
                0: cmdQ.push_front(8'h41);
                1: begin
                    trunc = $urandom_range(1, cmdQ.size() - 1);
                    while (cmdQ.size() > trunc) void'(cmdQ.pop_back());
                end
                default: ;
            endcase
            applyStimulus(3);
        end
        waitIdle(400);
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dbg_bus_master.md
Name: dbg_bus_master

Overview:
- Byte-stream-driven bus initiator for the device bridge. It is the initiator end of the interface the CPU normally drives.
- Parses commands from the UART receive byte stream and arbitrates for the bridge with the CPU (req/gnt).
- Issues single-word device reads and writes, and returns read data as bytes to the UART transmit side.
- Used for board bring-up: poke timer, LED and tube registers without software.

Parameters:
- TIMEOUT_CYCLES, 1000000, inter-byte timeout in clk cycles while a command is partially received; 0 disables the timeout.
- CMD_WRITE, 8'h57, command byte for a word write ('W').
- CMD_READ, 8'h52, command byte for a word read ('R').

Ports:
- clk  in  1  system clock (same domain as CPU/bridge)
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe: rx_data valid
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid; held until accepted
- tx_ready  in  1  transmitter accepts byte when tx_valid && tx_ready
- bus_req  out  1  request bridge ownership from CPU
- bus_gnt  in  1  CPU has released bridge; level, held while bus_req=1
- dev_addr  out  32  device address to bridge, bits [1:0] forced 0
- dev_wdata  out  32  write data to bridge
- dev_we  out  1  one-cycle write strobe to bridge
- dev_rdata  in  32  bridge read mux output (combinational from dev_addr)
- busy  out  1  state != IDLE
- overrun  out  1  sticky: byte arrived while it could not be accepted

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; shift regs, byte counter and timeout counter cleared; overrun cleared. bus_req drops immediately.
- States: IDLE, ADDR, DATA, REQ, ACCESS, RESP.
- IDLE:
  - rx_valid with CMD_WRITE or CMD_READ: latch op, byte count=0, go to ADDR.
  - Any other byte is silently discarded.
- ADDR:
  - Each rx_valid shifts rx_data into the address MSB-first.
  - After the 4th byte: write op goes to DATA; read op goes to REQ.
- DATA:
  - 4 bytes shifted MSB-first into dev_wdata.
  - After the 4th byte, go to REQ.
- Timeout (ADDR/DATA only):
  - Counter reloads on every accepted byte.
  - If TIMEOUT_CYCLES cycles elapse with no byte, go to IDLE and discard the partial command.
  - rx_valid in the expiring cycle wins: byte accepted, no timeout.
- REQ:
  - bus_req=1 from the first REQ cycle.
  - When bus_gnt is sampled 1, go to ACCESS next cycle.
  - No timeout in REQ; waits indefinitely.
- ACCESS (exactly 1 cycle):
  - dev_addr valid throughout.
  - Write: dev_we=1 this cycle only.
  - Read: dev_rdata registered at the end of this cycle.
  - bus_req stays 1 through ACCESS and drops on exit.
- Exit from ACCESS:
  - Read: go to RESP.
  - Write: go to IDLE (see optional feature).
- RESP:
  - tx_valid=1, tx_data = read word byte 3, then 2, 1, 0.
  - Each byte advances on tx_valid && tx_ready.
  - Next byte is presented the following cycle, so back-to-back bytes are possible.
  - After byte 0 is accepted, tx_valid=0 and go to IDLE.
- rx_valid while in REQ, ACCESS or RESP: byte dropped and overrun set to 1 (sticky until reset).
- dev_addr/dev_wdata hold their last values when idle; dev_we is 0 outside ACCESS.
- Latency from the final command byte's rx_valid cycle:
  - bus_req rises 1 cycle later.
  - With bus_gnt already high, dev_we/read sample occurs 2 cycles later.
  - First tx_valid occurs 3 cycles later.

Optional Feature:
- Macro: DBG_WRITE_ACK_EN.
- Defined:
  - After a write's ACCESS cycle, enter RESP and send a single ack byte 8'h4B ('K').
  - Overrun rules apply during the ack.
  - Go to IDLE on acceptance.
- Undefined:
  - Writes produce no tx traffic; ACCESS goes straight to IDLE.

Test Plan:
- Write, bus_gnt tied 1: rx 57 00 00 7F 00 00 00 00 0A.
  - dev_we high exactly 1 cycle, 2 cycles after the last byte, with dev_addr=32'h00007F00 and dev_wdata=32'h0000000A.
  - bus_req high for 2 cycles; no tx (ack 4B with DBG_WRITE_ACK_EN).
- Read, dev_rdata model returns 32'hDEADBEEF at 32'h00007F2C, tx_ready tied 1:
  - rx 52 00 00 7F 2F.
  - dev_addr=32'h00007F2C (low bits forced 0).
  - tx bytes DE AD BE EF on 4 consecutive cycles.
- Arbitration: bus_gnt held 0 for 50 cycles after the command completes.
  - bus_req stays 1 and no dev_we occurs.
  - Raise gnt: access occurs 1 cycle later.
- Timeout, TIMEOUT_CYCLES=16: rx 57 00 00, then silence.
  - busy falls after 16 idle cycles.
  - Next bytes 52 00 00 00 04 complete a read of 32'h00000004.
- Overrun/garbage:
  - Byte 41 in IDLE is ignored.
  - During RESP with tx_ready=0, send rx byte 52: overrun=1, response unchanged.
  - Async reset mid-RESP: tx_valid/bus_req go 0 immediately, busy=0, overrun=0.
